// File: rtl/stage_mem_if.sv
// Memory-side handshake bundle of the memory-access stage.
// The master side is the pipeline stage. The slave side is the memory or bus adapter.
interface stage_mem_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/stage_mem.sv
// RV32 memory-access stage: runs the load/store handshake, then aligns and extends load data.
// It also registers the write-back result and stalls upstream while an access is outstanding.
module stage_mem (
  input  logic               clk,
  input  logic               rst,
  input  logic               Done_I,
  input  logic [31:0]        PC_I,
  input  logic [5:0]         MCR,
  input  logic [31:0]        WDR,
  input  logic [31:0]        ASR,
  input  logic [4:0]         RAR,
  input  logic [2:0]         F3R,
  stage_mem_if.master        mem,
  output logic               Feedback_Mem_Acc,
  output logic               Done_O,
  output logic [31:0]        PC_O,
  output logic [4:0]         RF_waddr,
  output logic [31:0]        RF_wdata,
  output logic               RF_wen
);

  typedef enum logic [1:0] {IDLE, REQ, RDW} state_t;

  state_t      state_reg, state_next;
  logic        memop;
  logic        cmpl;
  logic        load_cmpl;
  logic        mem_write;
  logic        mem_read;
  logic        rd_ready;
  logic [4:0]  sh;
  logic [15:0] w_half;
  logic [31:0] load_data;

  assign memop = Done_I & (MCR[5] | MCR[4]);

  always_comb begin
    state_next = state_reg;
    cmpl       = 1'b0;
    load_cmpl  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    rd_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memop) state_next = REQ;
        else       cmpl       = Done_I;
      end
      REQ: begin
        mem_write = MCR[5];
        mem_read  = MCR[4];
        if (mem.Mem_Req_Ready) begin
          // A request with MemW set is treated as a store even if MemR is also set
          if (MCR[5]) begin
            cmpl       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RDW;
          end
        end
      end
      RDW: begin
        rd_ready = 1'b1;
        if (mem.Read_data_Valid) begin
          cmpl       = 1'b1;
          load_cmpl  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Low in the completion cycle, so execute advances on the same edge as write-back
  assign Feedback_Mem_Acc = memop & ~cmpl & ~rst;

  assign mem.Address         = {ASR[31:2], 2'b00};
  assign mem.Write_data      = WDR;
  assign mem.Write_strb      = MCR[3:0];
  assign mem.MemWrite        = mem_write;
  assign mem.MemRead         = mem_read;
  assign mem.Read_data_Ready = rd_ready;

  assign sh     = {ASR[1:0], 3'b000};
  assign w_half = 16'(mem.Read_data >> sh);

  always_comb begin
    case (F3R)
      3'b000:  load_data = {{24{w_half[7]}}, w_half[7:0]};
      3'b100:  load_data = {24'h0, w_half[7:0]};
      3'b001:  load_data = {{16{w_half[15]}}, w_half};
      3'b101:  load_data = {16'h0, w_half};
      default: load_data = mem.Read_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      Done_O    <= 1'b0;
      RF_wen    <= 1'b0;
      RF_waddr  <= 5'd0;
      RF_wdata  <= 32'd0;
      PC_O      <= 32'd0;
    end else begin
      state_reg <= state_next;
      Done_O    <= cmpl;
      RF_wen    <= cmpl & (RAR != 5'd0) & ~MCR[5];
      if (cmpl) begin
        PC_O     <= PC_I;
        RF_waddr <= RAR;
        RF_wdata <= load_cmpl ? load_data : ASR;
      end
    end
  end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access stage of the 5-stage RV32 turbo pipeline; it sits between the execute stage and write-back. It consumes the execute stage's output registers, runs the valid/ready memory handshake for loads and stores, and aligns and sign-extends load data. It forwards the completed result to write-back and holds `Feedback_Mem_Acc` high to freeze the upstream stages while a memory access is outstanding.

## Interface
- No parameters.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `Done_I` input 1: execute-stage output registers hold a valid instruction.
- `PC_I` input 32: instruction PC.
- `MCR` input 6: {MemW, MemR, Write_strb[3:0]}.
- `WDR` input 32: store data, already lane-shifted.
- `ASR` input 32: ALU/shift result, or the memory byte address.
- `RAR` input 5: destination register (0 = none).
- `F3R` input 3: funct3.
- `Address` output 32: `{ASR[31:2],2'b00}`.
- `MemWrite` output 1: store request.
- `Write_data` output 32: `WDR`.
- `Write_strb` output 4: `MCR[3:0]`.
- `MemRead` output 1: load request.
- `Mem_Req_Ready` input 1: memory accepts the request this cycle.
- `Read_data` input 32: load data word.
- `Read_data_Valid` input 1: `Read_data` is valid.
- `Read_data_Ready` output 1: stage accepts read data.
- `Feedback_Mem_Acc` output 1: stall the upstream stages (their clocks are gated).
- `Done_O` output 1: write-back registers hold a completed instruction.
- `PC_O` output 32: PC of that instruction.
- `RF_waddr` output 5: destination register.
- `RF_wdata` output 32: write-back data.
- `RF_wen` output 1: register-file write enable.

## Operation
- Define `memop = Done_I & (MCR[5] | MCR[4])`.
- The upstream registers are frozen while `Feedback_Mem_Acc` is high, so all inputs are stable for the whole access.
- FSM states: IDLE, REQ, RDW.
  - IDLE: if `memop`, go to REQ. Otherwise stay.
  - REQ: drive `MemWrite = MCR[5]` and `MemRead = MCR[4]`.
    - On `Mem_Req_Ready` with a store: the store completes and the FSM goes to IDLE.
    - On `Mem_Req_Ready` with a load: go to RDW.
    - Otherwise stay in REQ.
  - RDW: drive `Read_data_Ready = 1`. On `Read_data_Valid`, the load completes and the FSM goes to IDLE.
- `MemWrite`, `MemRead` and `Read_data_Ready` are decoded from the state only. They are 0 in IDLE.
- Completion (`cmpl`) is one of:
  - `Done_I & ~memop` in IDLE (non-memory op: one cycle, no stall).
  - A store handshake in REQ.
  - `Read_data_Valid` in RDW.
- `Feedback_Mem_Acc = memop & ~cmpl`. It is combinational and is low in the completion cycle so the execute stage advances on the same edge.
- On every edge, write-back registers load as follows:
  - `Done_O <= cmpl`.
  - If `cmpl`: `PC_O <= PC_I`, `RF_waddr <= RAR`, `RF_wen <= (RAR != 0) & ~MCR[5]`.
  - `RF_wdata` is the aligned load data for loads, otherwise `ASR`.
  - When not completing, `Done_O` and `RF_wen` are 0 and the other registers hold.
- Load alignment: `sh = ASR[1:0]*8`, `w = Read_data >> sh`.
  - F3R 000 (LB): sign-extend `w[7:0]`.
  - F3R 100 (LBU): zero-extend `w[7:0]`.
  - F3R 001 (LH): sign-extend `w[15:0]`.
  - F3R 101 (LHU): zero-extend `w[15:0]`.
  - F3R 010 (LW): `Read_data`.
  - Any other F3R value returns `Read_data`.
- Halfword/word alignment of the address is the responsibility of the execute stage; it is not checked here.

## Timing
- Reset values (also on reset mid-access): state IDLE, and all of the following are 0: `Done_O`, `RF_wen`, `RF_waddr`, `RF_wdata`, `PC_O`, `MemWrite`, `MemRead`, `Read_data_Ready`.
- Reset abandons any outstanding request; no `Done_O` is produced for it.
- `Feedback_Mem_Acc` is forced 0 while `rst` is high.
- Non-memory op: `Done_O` rises 1 cycle after `Done_I` is presented.
- Store with ready in the first REQ cycle: cycle 0 IDLE, cycle 1 REQ handshake, `Done_O` high in cycle 2. Each ready-low cycle adds one cycle.
- Load with ready in the first REQ cycle and valid in the first RDW cycle: cycle 0 IDLE, cycle 1 REQ, cycle 2 RDW valid, `Done_O` in cycle 3. Each wait cycle on ready or valid adds one cycle.
- Back-to-back operations: the instruction after a completion is seen in IDLE on the very next cycle. No bubble is inserted beyond `Done_O = 0` during stalls.
- `Read_data_Valid` outside RDW is ignored. `Mem_Req_Ready` outside REQ is ignored.

## Test plan
- ALU op, `Done_I=1`, `MCR=0`, `ASR=0x1234`, `RAR=5` -> next cycle `Done_O=1`, `RF_wen=1`, `RF_waddr=5`, `RF_wdata=0x1234`. `Feedback_Mem_Acc` is never high.
- SW, `ASR=0x100`, `WDR=0xDEADBEEF`, `MCR=6'b10_1111`, `Mem_Req_Ready` low for 2 REQ cycles -> `MemWrite` high for 3 cycles with `Address=0x100`. `Feedback_Mem_Acc` high for 3 cycles. `Done_O=1`, `RF_wen=0` on the cycle after the handshake.
- LB, `ASR=0x203`, `Read_data=0x80FF_0000` -> `RF_wdata=0xFFFF_FF80`, `Address=0x200`.
- LHU, `ASR=0x202`, `Read_data=0x8001_0000` -> `RF_wdata=0x0000_8001`. LW with `RAR=0` -> `Done_O=1`, `RF_wen=0`.
- `rst` asserted in RDW -> next cycle state IDLE, `Read_data_Ready=0`, `Done_O=0`. A later `Read_data_Valid` pulse produces no `Done_O`.
- Load followed by an ALU op -> `Done_O` pulses in two consecutive cycles, with the correct PCs and data in order.
